// File: rtl/adder_bit32_sync.sv
// 32-bit registered adder/subtractor built from eight 4-bit carry-lookahead groups
// with ripple carry between groups; results appear one cycle after the operands.
module adder_bit32_sync (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        sub,
    output logic [31:0] out,
    output logic        cout
);

    localparam int unsigned NUM_GROUPS = 8;
    localparam int unsigned GROUP_W    = 4;

    logic [31:0]           in1_x;
    logic [31:0]           gen_bit;
    logic [31:0]           prop_bit;
    logic [31:0]           sum_bit;
    logic [NUM_GROUPS:0]   group_carry;

    logic [31:0] out_d;
    logic [31:0] out_q;
    logic        cout_d;
    logic        cout_q;

    // Subtract is invert-and-add-one: sub flips operand B and feeds the carry-in.
    assign in1_x          = in1 ^ {32{sub}};
    assign gen_bit        = in0 & in1_x;
    assign prop_bit       = in0 ^ in1_x;
    assign group_carry[0] = sub;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_cla
            logic [GROUP_W-1:0] g;
            logic [GROUP_W-1:0] p;
            logic [GROUP_W:0]   c;

            assign g    = gen_bit[gi*GROUP_W +: GROUP_W];
            assign p    = prop_bit[gi*GROUP_W +: GROUP_W];
            assign c[0] = group_carry[gi];

            // Every in-group carry is a flat sum of products of the group inputs.
            assign c[1] = g[0]
                        | (p[0] & c[0]);
            assign c[2] = g[1]
                        | (p[1] & g[0])
                        | (p[1] & p[0] & c[0]);
            assign c[3] = g[2]
                        | (p[2] & g[1])
                        | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = g[3]
                        | (p[3] & g[2])
                        | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0])
                        | (p[3] & p[2] & p[1] & p[0] & c[0]);

            assign sum_bit[gi*GROUP_W +: GROUP_W] = p ^ c[GROUP_W-1:0];
            assign group_carry[gi+1]              = c[GROUP_W];
        end
    endgenerate

    // NOTE: give every always_comb output a value at the top so no path infers a latch.
    always_comb begin
        out_d  = sum_bit;
        cout_d = group_carry[NUM_GROUPS];
    end

    // NOTE: registers are assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= 32'h0;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_bit32_sync.sv
// Directed and random vectors for adder_bit32_sync, checked one cycle after issue.
module tb_adder_bit32_sync;

    logic        clk;
    logic        rst;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        sub;
    logic [31:0] out;
    logic        cout;

    int checks   = 0;
    int failures = 0;

    adder_bit32_sync dut (
        .clk  (clk),
        .rst  (rst),
        .in0  (in0),
        .in1  (in1),
        .sub  (sub),
        .out  (out),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_out, input logic exp_cout);
        checks++;
        assert ({cout, out} === {exp_cout, exp_out})
        else begin
            failures++;
            $error("FAIL %s: got out=%h cout=%b, expected out=%h cout=%b",
                   tag, out, cout, exp_out, exp_cout);
        end
    endtask

    // Drive a vector on the falling edge, let one rising edge register it, then sample.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
        @(negedge clk);
        in0 = a;
        in1 = b;
        sub = s;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] exp_out, input logic exp_cout);
        apply(a, b, s, 1'b0);
        check(tag, exp_out, exp_cout);
    endtask

    initial begin
        logic [32:0] model;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst = 1'b1;
        in0 = 32'h1234_5678;
        in1 = 32'h9ABC_DEF0;
        sub = 1'b0;

        apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        check("reset", 32'h0, 1'b0);

        vec("sub_6_5",        32'd6,         32'd5,         1'b1, 32'd1,         1'b1);
        vec("add_543_675",    32'd543,       32'd675,       1'b0, 32'd1218,      1'b0);
        vec("sub_543_675",    32'd543,       32'd675,       1'b1, 32'hFFFF_FF7C, 1'b0);
        vec("sub_675_543",    32'd675,       32'd543,       1'b1, 32'd132,       1'b1);
        vec("add_m32_45",     32'hFFFF_FFE0, 32'd45,        1'b0, 32'd13,        1'b1);
        vec("sub_m32_45",     32'hFFFF_FFE0, 32'd45,        1'b1, 32'hFFFF_FFB3, 1'b1);
        vec("add_1_ffff",     32'd1,         32'hFFFF_FFFF, 1'b0, 32'd0,         1'b1);
        vec("sub_1_ffff",     32'd1,         32'hFFFF_FFFF, 1'b1, 32'd2,         1'b0);
        vec("add_ffff_1",     32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         1'b1);
        vec("sub_equal",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'd0,         1'b1);
        vec("sub_0_0",        32'd0,         32'd0,         1'b1, 32'd0,         1'b1);
        vec("add_0_0",        32'd0,         32'd0,         1'b0, 32'd0,         1'b0);
        vec("add_group_ripple", 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0);

        // Operands moving between edges must not disturb the registered result.
        vec("hold_base",      32'd100,       32'd23,        1'b0, 32'd123,       1'b0);
        in0 = 32'hFFFF_FFFF;
        in1 = 32'hFFFF_FFFF;
        sub = 1'b1;
        #2;
        check("hold_between_edges", 32'd123, 1'b0);

        // Reset on the same edge as a valid vector drops that result.
        apply(32'd7, 32'd8, 1'b0, 1'b1);
        check("reset_overrides", 32'h0, 1'b0);
        vec("after_reset",    32'd7,         32'd8,         1'b0, 32'd15,        1'b0);

        // Back-to-back random operations, one issued every cycle.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb ^ {32{rs}}} + {32'h0, rs};
            apply(ra, rb, rs, 1'b0);
            check($sformatf("random_%0d", i), model[31:0], model[32]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
